// File: rtl/processor_memory_arbiter_if.sv
// Avalon-MM master-side bundle shared by the CPU and DMA ports.
// The arbiter sees each master through the slave modport.
interface processor_memory_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/processor_memory_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters.
// Commands pass through combinationally; read data returns one cycle later.
module processor_memory_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int DEPTH  = 5120
) (
    input  logic                  clk,
    input  logic                  reset,
    processor_memory_arbiter_if.slave m0,
    processor_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  oor_error
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    logic last_grant_q, last_grant_d;
    logic rd_valid_q, rd_valid_d;
    logic rd_owner_q, rd_owner_d;
    logic rd_oor_q, rd_oor_d;
    logic oor_error_q, oor_error_d;

    logic              req0, req1;
    logic              grant0, grant1, grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_read, sel_write;
    logic              in_range;
    logic              rdv0, rdv1;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        req0 = m0.read | m0.write;
        req1 = m1.read | m1.write;

        // last_grant_q == 1 means m1 won last, so m0 wins contention
        grant0    = ~reset & req0 & (~req1 | last_grant_q);
        grant1    = ~reset & req1 & ~grant0;
        grant_any = grant0 | grant1;

        m0.waitrequest = reset | (req0 & ~grant0);
        m1.waitrequest = reset | (req1 & ~grant1);

        sel_addr  = grant1 ? m1.address : m0.address;
        sel_read  = grant1 ? m1.read    : m0.read;
        sel_write = grant1 ? m1.write   : m0.write;
        in_range  = {1'b0, sel_addr} < DEPTH_W;

        mem_address    = sel_addr;
        mem_byteenable = grant1 ? m1.byteenable : m0.byteenable;
        mem_writedata  = grant1 ? m1.writedata  : m0.writedata;
        mem_chipselect = grant_any & in_range;
        mem_write      = grant_any & in_range & sel_write;
        mem_clken      = ~reset;

        last_grant_d = grant_any ? grant1 : last_grant_q;
        // read+write together is a write, so no return is scheduled
        rd_valid_d   = grant_any & sel_read & ~sel_write;
        rd_owner_d   = grant1;
        rd_oor_d     = ~in_range;
        oor_error_d  = grant_any & ~in_range;
    end

    always_comb begin
        rd_data = rd_oor_q ? '0 : mem_readdata;
        rdv0    = ~reset & rd_valid_q & ~rd_owner_q;
        rdv1    = ~reset & rd_valid_q & rd_owner_q;

        m0.readdatavalid = rdv0;
        m1.readdatavalid = rdv1;
        m0.readdata      = rdv0 ? rd_data : '0;
        m1.readdata      = rdv1 ? rd_data : '0;
        oor_error        = oor_error_q & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
            oor_error_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
            oor_error_q  <= oor_error_d;
        end
    end

endmodule

// File: tb/tb_processor_memory_arbiter.sv
// Bench for processor_memory_arbiter: directed scenarios then random
// traffic, checked against a transaction-level model of the arbiter.
module tb_processor_memory_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int DEPTH  = 5120;

    typedef struct {
        logic              r;
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic              oor_error;

    processor_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_if ();
    processor_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_if ();

    processor_memory_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m0(m0_if.slave),
        .m1(m1_if.slave),
        .mem_address(mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .oor_error(oor_error)
    );

    always #5 clk = ~clk;

    // RAM: registered address, unregistered q
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic [ADDR_W-1:0] ram_addr_q = '0;
    assign mem_readdata = ram[ram_addr_q];

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write)
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end

    // Transaction-level model state
    logic [DATA_W-1:0] ref_mem [int];
    int                last_w;
    bit                pend_v;
    int                pend_owner;
    logic [DATA_W-1:0] pend_data;
    bit                oor_next;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    function automatic cmd_t idle();
        cmd_t c;
        c.r = 0; c.w = 0; c.a = '0; c.d = '0; c.be = '0;
        return c;
    endfunction

    function automatic cmd_t rd(input int a);
        cmd_t c = idle();
        c.r = 1; c.a = ADDR_W'(a);
        return c;
    endfunction

    function automatic cmd_t wr(input int a, input logic [31:0] d, input logic [3:0] be);
        cmd_t c = idle();
        c.w = 1; c.a = ADDR_W'(a); c.d = d; c.be = be;
        return c;
    endfunction

    function automatic logic [31:0] mem_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    task automatic cycle(input logic rst, input cmd_t c0, input cmd_t c1);
        bit   q0, q1, any, in_rng;
        int   win;
        cmd_t wc;
        reset           = rst;
        m0_if.read      = c0.r;  m0_if.write = c0.w;
        m0_if.address   = c0.a;  m0_if.writedata = c0.d;
        m0_if.byteenable = c0.be;
        m1_if.read      = c1.r;  m1_if.write = c1.w;
        m1_if.address   = c1.a;  m1_if.writedata = c1.d;
        m1_if.byteenable = c1.be;
        @(negedge clk);
        q0  = c0.r | c0.w;
        q1  = c1.r | c1.w;
        any = !rst && (q0 || q1);
        if (q0 && q1) win = 1 - last_w;
        else          win = q1 ? 1 : 0;
        wc     = (win == 1) ? c1 : c0;
        in_rng = int'(wc.a) < DEPTH;

        chk("wait0", m0_if.waitrequest, rst ? 1 : (q0 && !(any && win == 0)));
        chk("wait1", m1_if.waitrequest, rst ? 1 : (q1 && !(any && win == 1)));
        chk("rdv0", m0_if.readdatavalid, !rst && pend_v && pend_owner == 0);
        chk("rdv1", m1_if.readdatavalid, !rst && pend_v && pend_owner == 1);
        chk("rdata0", m0_if.readdata,
            (!rst && pend_v && pend_owner == 0) ? pend_data : 32'h0);
        chk("rdata1", m1_if.readdata,
            (!rst && pend_v && pend_owner == 1) ? pend_data : 32'h0);
        chk("oor", oor_error, !rst && oor_next);
        chk("clken", mem_clken, !rst);
        chk("cs", mem_chipselect, any && in_rng);
        if (any && in_rng) begin
            chk("maddr", mem_address, wc.a);
            chk("mwrite", mem_write, wc.w);
            if (wc.w) begin
                chk("mwdata", mem_writedata, wc.d);
                chk("mbe", mem_byteenable, wc.be);
            end
        end else if (!any) begin
            chk("mwrite_idle", mem_write, 0);
        end

        if (rst) begin
            last_w   = 1;
            pend_v   = 0;
            oor_next = 0;
        end else begin
            pend_v   = any && wc.r && !wc.w;
            oor_next = any && !in_rng;
            if (any) begin
                last_w     = win;
                pend_owner = win;
                pend_data  = in_rng ? mem_rd(int'(wc.a)) : 32'h0;
                if (wc.w && in_rng) begin
                    logic [31:0] v = mem_rd(int'(wc.a));
                    for (int b = 0; b < 4; b++)
                        if (wc.be[b]) v[8*b +: 8] = wc.d[8*b +: 8];
                    ref_mem[int'(wc.a)] = v;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        cmd_t c0, c1;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        last_w = 1; pend_v = 0; pend_owner = 0; pend_data = '0; oor_next = 0;
        reset = 1;
        @(posedge clk);
        #1;

        cycle(1, idle(), idle());
        cycle(1, rd(3), wr(4, 32'h1, 4'hF));

        cycle(0, wr(16, 32'hCAFEF00D, 4'hF), idle());
        cycle(0, rd(16), idle());
        cycle(0, idle(), idle());
        chk("t1_data_model", pend_data, 32'hCAFEF00D);

        for (int i = 0; i < 6; i++)
            cycle(0, rd(16), wr(100 + i, 32'hA0 + i, 4'hF));
        for (int i = 0; i < 6; i++)
            cycle(0, rd(100 + i), rd(16));
        cycle(0, idle(), idle());

        cycle(0, wr(32, 32'hFFFFFFFF, 4'hF), idle());
        cycle(0, wr(32, 32'h00000000, 4'b0101), idle());
        cycle(0, rd(32), idle());
        chk("t3_model_bytes", pend_data, 32'hFF00FF00);
        cycle(0, idle(), idle());

        cycle(0, idle(), rd(5120));
        cycle(0, idle(), idle());
        cycle(0, idle(), wr(5121, 32'hDEADBEEF, 4'hF));
        cycle(0, idle(), idle());

        cycle(0, rd(16), idle());
        cycle(1, idle(), idle());
        cycle(0, idle(), idle());
        cycle(0, rd(32), rd(16));
        cycle(0, rd(32), rd(16));
        cycle(0, idle(), idle());

        c1 = wr(7, 32'h12345678, 4'hF);
        c1.r = 1;
        cycle(0, idle(), c1);
        cycle(0, idle(), idle());
        cycle(0, idle(), rd(7));
        cycle(0, idle(), idle());
        chk("ram7", ram[7], 32'h12345678);

        for (int i = 0; i < 400; i++) begin
            cmd_t cs [2];
            for (int m = 0; m < 2; m++) begin
                int k = $urandom_range(0, 9);
                cs[m] = idle();
                cs[m].r  = (k < 4) || (k == 8);
                cs[m].w  = (k >= 4 && k < 7) || (k == 8);
                cs[m].a  = ($urandom_range(0, 9) == 0)
                         ? ADDR_W'($urandom_range(5116, 5125))
                         : ADDR_W'($urandom_range(0, 15));
                cs[m].d  = $urandom;
                cs[m].be = 4'($urandom);
            end
            c0 = cs[0];
            c1 = cs[1];
            cycle($urandom_range(0, 39) == 0, c0, c1);
        end
        cycle(0, idle(), idle());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
